// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: registered pipeline hazard controller producing per-latch stall/flush and PC enable.
// Define HZU_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl_unit #(
  parameter int REGW     = 5,
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dreq_mem,
  input  logic             branch_ex,
  input  logic             alu_zf,
  input  logic             jump_ex,
  input  logic             memread_ex,
  input  logic [REGW-1:0]  rd_ex,
  input  logic [REGW-1:0]  rs_id,
  input  logic [REGW-1:0]  rt_id,
  input  logic             halt_wb,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_xmem,
  output logic             stall_wb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_xmem,
  output logic             flush_wb,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LUSTALL, DWAIT, HALT} state_e;

  localparam logic [1:0] LU_LOAD = 2'(LU_STALL - 1);

  state_e     state_q, state_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic       lu, tk, dwait_hold, resume_lus;

  assign lu = memread_ex && (rd_ex != '0) && ((rd_ex == rs_id) || (rd_ex == rt_id));
  assign tk = (branch_ex && alu_zf) || jump_ex;
  // Once waiting, only dhit matters; a fresh request stalls only until its own hit.
  assign dwait_hold = (state_q == DWAIT) ? !dhit : (dreq_mem && !dhit);
  // A non-zero count parked in DWAIT means the wait interrupted a load-use bubble.
  assign resume_lus = (state_q == DWAIT) && (lu_cnt_q != 2'd0);

  always_comb begin
    stall_ifid = 1'b0;
    stall_idex = 1'b0;
    stall_xmem = 1'b0;
    stall_wb   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    flush_xmem = 1'b0;
    flush_wb   = 1'b0;
    pc_en      = 1'b0;
    halted     = 1'b0;
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;

    if (!nRST) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      flush_xmem = 1'b1;
      flush_wb   = 1'b1;
      state_d    = RUN;
      lu_cnt_d   = 2'd0;
    end else if ((state_q == HALT) || halt_wb) begin
      stall_ifid = 1'b1;
      stall_idex = 1'b1;
      stall_xmem = 1'b1;
      stall_wb   = 1'b1;
      halted     = 1'b1;
      state_d    = HALT;
    end else if (dwait_hold) begin
      stall_ifid = 1'b1;
      stall_idex = 1'b1;
      stall_xmem = 1'b1;
      stall_wb   = 1'b1;
      state_d    = DWAIT;
    end else if (tk) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      pc_en      = 1'b1;
      state_d    = RUN;
      lu_cnt_d   = 2'd0;
    end else if (state_q == LUSTALL) begin
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
      lu_cnt_d   = lu_cnt_q - 2'd1;
      state_d    = (lu_cnt_q == 2'd1) ? RUN : LUSTALL;
    end else begin
      // RUN evaluation, also used on the cycle a data wait completes.
      state_d  = resume_lus ? LUSTALL : RUN;
      lu_cnt_d = resume_lus ? lu_cnt_q : 2'd0;
      if (lu) begin
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
        if ((LU_STALL > 1) && !resume_lus) begin
          lu_cnt_d = LU_LOAD;
          state_d  = LUSTALL;
        end
      end else if (!ihit) begin
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= RUN;
      lu_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

`ifdef HZU_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Only a taken redirect flushes while the PC advances.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && !halted && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_ifid && pc_en && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
